sys_onchip_mem_mover: RTL and testbench

- Avalon-MM master that drives the s1/s2 slave ports of the on-chip RAM from the initiator side.
- Accepts one block command at a time: copy N words from src to dst, or fill N words with a constant.
- Issues single-word reads and writes, honouring waitrequest and readdatavalid.
- Sits between the RISC-V control logic (or the HPS bridge) and the memory interconnect. Used for buffer initialisation and frame copies without CPU load-store loops.

---
 rtl/sys_onchip_mem_mover.sv | 105 ++++++++++
 tb/tb_sys_onchip_mem_mover.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/sys_onchip_mem_mover.sv
// sys_onchip_mem_mover: Avalon-MM master that copies or fills blocks of on-chip RAM one word at a time
module sys_onchip_mem_mover #(
    parameter int ADDR_W = 15,
    parameter int LEN_W  = 14
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_op,
    input  logic [ADDR_W-1:0] cmd_src,
    input  logic [ADDR_W-1:0] cmd_dst,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic [31:0]       cmd_fill,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W-1:0] avm_address,
    output logic              avm_read,
    output logic              avm_write,
    output logic [31:0]       avm_writedata,
    output logic [3:0]        avm_byteenable,
    input  logic [31:0]       avm_readdata,
    input  logic              avm_readdatavalid,
    input  logic              avm_waitrequest
);
    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] RD_REQ  = 3'd1;
    localparam logic [2:0] RD_WAIT = 3'd2;
    localparam logic [2:0] WR_REQ  = 3'd3;
    localparam logic [2:0] FINISH  = 3'd4;

    logic [2:0]        state_q, state_d;
    logic [ADDR_W-1:0] src_q, src_d, dst_q, dst_d;
    logic [LEN_W-1:0]  cnt_q, cnt_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              op_q, op_d, err_q, err_d;
    logic              bad;

    // Command decode, word sequencing and address/count bookkeeping
    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        dst_d   = dst_q;
        cnt_d   = cnt_q;
        wdata_d = wdata_q;
        op_d    = op_q;
        err_d   = err_q;
        bad     = (cmd_dst[1:0] != 2'b00) || (!cmd_op && cmd_src[1:0] != 2'b00);
        case (state_q)
            IDLE: if (cmd_valid) begin
                src_d   = cmd_src;
                dst_d   = cmd_dst;
                cnt_d   = cmd_len;
                op_d    = cmd_op;
                wdata_d = cmd_fill;
                err_d   = bad;
                state_d = (bad || cmd_len == '0) ? FINISH : cmd_op ? WR_REQ : RD_REQ;
            end
            RD_REQ: state_d = avm_waitrequest ? RD_REQ : RD_WAIT;
            RD_WAIT: if (avm_readdatavalid) begin
                wdata_d = avm_readdata;
                state_d = WR_REQ;
            end
            WR_REQ: if (!avm_waitrequest) begin
                src_d   = src_q + ADDR_W'(4);
                dst_d   = dst_q + ADDR_W'(4);
                cnt_d   = cnt_q - LEN_W'(1);
                state_d = (cnt_q == LEN_W'(1)) ? FINISH : op_q ? WR_REQ : RD_REQ;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers, all cleared by reset so a pending transfer is dropped
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            src_q   <= '0;
            dst_q   <= '0;
            cnt_q   <= '0;
            wdata_q <= '0;
            op_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            cnt_q   <= cnt_d;
            wdata_q <= wdata_d;
            op_q    <= op_d;
            err_q   <= err_d;
        end
    end

    assign cmd_ready      = state_q == IDLE;
    assign busy           = state_q != IDLE;
    assign done           = state_q == FINISH;
    assign err            = err_q;
    assign avm_read       = state_q == RD_REQ;
    assign avm_write      = state_q == WR_REQ;
    assign avm_address    = (state_q == RD_REQ) ? src_q : dst_q;
    assign avm_writedata  = wdata_q;
    assign avm_byteenable = 4'hF;
endmodule

// File: tb/tb_sys_onchip_mem_mover.sv
// tb_sys_onchip_mem_mover: vector-table bench with a RAM slave model and a reference memory
module tb_sys_onchip_mem_mover;
    localparam int AW = 15;
    localparam int LW = 14;

    logic          clk = 1'b0;
    logic          reset;
    logic          cmd_valid, cmd_ready, cmd_op;
    logic [AW-1:0] cmd_src, cmd_dst;
    logic [LW-1:0] cmd_len;
    logic [31:0]   cmd_fill;
    logic          busy, done, err;
    logic [AW-1:0] avm_address;
    logic          avm_read, avm_write;
    logic [31:0]   avm_writedata, avm_readdata;
    logic [3:0]    avm_byteenable;
    logic          avm_readdatavalid, avm_waitrequest;

    always #5 clk = ~clk;

    sys_onchip_mem_mover #(.ADDR_W(AW), .LEN_W(LW)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_src(cmd_src), .cmd_dst(cmd_dst), .cmd_len(cmd_len), .cmd_fill(cmd_fill),
        .busy(busy), .done(done), .err(err),
        .avm_address(avm_address), .avm_read(avm_read), .avm_write(avm_write),
        .avm_writedata(avm_writedata), .avm_byteenable(avm_byteenable),
        .avm_readdata(avm_readdata), .avm_readdatavalid(avm_readdatavalid),
        .avm_waitrequest(avm_waitrequest)
    );

    // RAM slave model: read latency 1, programmable stall counts, protocol watchdog
    logic [31:0]   mem [0:8191];
    logic [31:0]   ref_mem [0:8191];
    logic          rdv_q = 1'b0;
    logic [31:0]   rdata_q = '0;
    logic          inj_rdv = 1'b0;
    logic [31:0]   inj_data = '0;
    int            rd_set = 0, wr_set = 0, rd_used = 0, wr_used = 0;
    int            cyc = 0, n_rd = 0, viol = 0;
    logic          p_st_rd = 1'b0, p_st_wr = 1'b0;
    logic [AW-1:0] p_addr = '0;
    logic [31:0]   p_data = '0;
    logic [AW-1:0] wl_addr [$];
    logic [31:0]   wl_data [$];

    assign avm_waitrequest   = (avm_read && rd_used < rd_set) || (avm_write && wr_used < wr_set);
    assign avm_readdatavalid = rdv_q | inj_rdv;
    assign avm_readdata      = inj_rdv ? inj_data : rdata_q;

    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rdv_q <= 1'b0;
        if (cyc == 0)
            for (int i = 0; i < 8192; i++) mem[i] <= 32'(i + 1);
        if ((avm_read && avm_write) ||
            (p_st_rd && !(avm_read && avm_address == p_addr)) ||
            (p_st_wr && !(avm_write && avm_address == p_addr && avm_writedata == p_data)))
            viol <= viol + 1;
        p_st_rd <= avm_read && avm_waitrequest;
        p_st_wr <= avm_write && avm_waitrequest;
        p_addr  <= avm_address;
        p_data  <= avm_writedata;
        if (avm_read && avm_waitrequest) rd_used <= rd_used + 1;
        if (avm_write && avm_waitrequest) wr_used <= wr_used + 1;
        if (avm_read && !avm_waitrequest) begin
            rdv_q   <= 1'b1;
            rdata_q <= mem[avm_address[AW-1:2]];
            n_rd    <= n_rd + 1;
        end
        if (avm_write && !avm_waitrequest) begin
            mem[avm_address[AW-1:2]] <= avm_writedata;
            wl_addr.push_back(avm_address);
            wl_data.push_back(avm_writedata);
        end
    end

    typedef struct {
        logic          op;
        logic [AW-1:0] src;
        logic [AW-1:0] dst;
        logic [LW-1:0] len;
        logic [31:0]   fill;
        int            rd_st;
        int            wr_st;
        int            lat;
        logic          poke;
    } vec_t;

    vec_t vt [9];
    vec_t vr;
    int   tests = 0, fails = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Issue one command, optionally re-raise cmd_valid while busy, and measure accept-to-done cycles
    task automatic run_cmd(input vec_t v, output int lat);
        int a;
        @(negedge clk);
        rd_set = rd_used + v.rd_st;
        wr_set = wr_used + v.wr_st;
        cmd_valid = 1'b1; cmd_op = v.op; cmd_src = v.src; cmd_dst = v.dst;
        cmd_len = v.len; cmd_fill = v.fill;
        @(posedge clk); #1;
        a = cyc;
        cmd_valid = 1'b0;
        lat = -1;
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            cmd_valid = v.poke && k == 0;
            cmd_dst   = v.dst + AW'(12'h100);
            if (done) begin
                lat = cyc - a + 1;
                break;
            end
        end
        cmd_valid = 1'b0;
    endtask

    task automatic do_vec(input vec_t v, input string tag);
        int            lat, bw, br, nw, mism, diffs;
        logic          exp_err;
        logic [AW-1:0] a, s;
        logic [31:0]   d;
        exp_err = (v.dst[1:0] != 2'b00) || (!v.op && v.src[1:0] != 2'b00);
        bw = wl_addr.size();
        br = n_rd;
        run_cmd(v, lat);
        chk({tag, "_lat"}, 64'(lat), 64'(v.lat));
        chk({tag, "_err"}, 64'(err), 64'(exp_err));
        @(negedge clk);
        chk({tag, "_pulse"}, {62'd0, done, cmd_ready}, 64'b01);
        nw = wl_addr.size() - bw;
        chk({tag, "_nwr"}, 64'(nw), exp_err ? 64'd0 : 64'(v.len));
        chk({tag, "_nrd"}, 64'(n_rd - br), (exp_err || v.op) ? 64'd0 : 64'(v.len));
        mism = 0;
        if (!exp_err)
            for (int i = 0; i < int'(v.len); i++) begin
                a = v.dst + AW'(4 * i);
                s = v.src + AW'(4 * i);
                d = v.op ? v.fill : ref_mem[s[AW-1:2]];
                ref_mem[a[AW-1:2]] = d;
                if (i >= nw || wl_addr[bw + i] !== a || wl_data[bw + i] !== d) mism++;
            end
        chk({tag, "_wseq"}, 64'(mism), 64'd0);
        diffs = 0;
        for (int i = 0; i < 8192; i++) if (mem[i] !== ref_mem[i]) diffs++;
        chk({tag, "_mem"}, 64'(diffs), 64'd0);
        chk({tag, "_proto"}, 64'(viol), 64'd0);
    endtask

    initial begin
        logic [56:0] rst_exp;
        int          bw;
        vt[0] = '{1'b1, 15'h0000, 15'h0100, 14'd4, 32'hA5A5_5A5A, 0, 0,  5, 1'b0};
        vt[1] = '{1'b0, 15'h0000, 15'h0200, 14'd3, 32'h0,         0, 0, 10, 1'b0};
        vt[2] = '{1'b0, 15'h0010, 15'h0300, 14'd1, 32'h0,         5, 3, 12, 1'b0};
        vt[3] = '{1'b1, 15'h0000, 15'h0102, 14'd4, 32'h1111_2222, 0, 0,  1, 1'b0};
        vt[4] = '{1'b0, 15'h0000, 15'h0400, 14'd2, 32'h0,         0, 0,  7, 1'b0};
        vt[5] = '{1'b0, 15'h0001, 15'h0500, 14'd2, 32'h0,         0, 0,  1, 1'b0};
        vt[6] = '{1'b1, 15'h0000, 15'h7FF8, 14'd3, 32'h1234_5678, 0, 0,  4, 1'b0};
        vt[7] = '{1'b1, 15'h0000, 15'h0600, 14'd0, 32'hFFFF_FFFF, 0, 0,  1, 1'b0};
        vt[8] = '{1'b0, 15'h0200, 15'h0204, 14'd2, 32'h0,         0, 0,  7, 1'b0};
        vr    = '{1'b1, 15'h0000, 15'h0900, 14'd2, 32'hCAFE_F00D, 0, 0,  3, 1'b1};
        for (int i = 0; i < 8192; i++) ref_mem[i] = 32'(i + 1);
        rst_exp = {6'b100000, 15'h0, 32'h0, 4'hF};
        reset = 1'b1; cmd_valid = 1'b0; cmd_op = 1'b0; cmd_src = '0; cmd_dst = '0;
        cmd_len = '0; cmd_fill = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_vals", 64'({cmd_ready, busy, done, err, avm_read, avm_write,
                               avm_address, avm_writedata, avm_byteenable}), 64'(rst_exp));
        reset = 1'b0;
        for (int i = 0; i < 9; i++) do_vec(vt[i], $sformatf("v%0d", i));

        // Reset while a 16-word copy waits for read data, then a stray readdatavalid
        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = 1'b0; cmd_src = 15'h0040; cmd_dst = 15'h0800; cmd_len = 14'd16;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        bw = wl_addr.size();
        @(negedge clk);
        chk("rst_rdreq", 64'({avm_read, avm_write, busy}), 64'b101);
        @(negedge clk);
        chk("rst_rdwait", 64'({avm_read, avm_write, busy}), 64'b001);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        inj_rdv = 1'b1; inj_data = 32'hBAD0_BAD0;
        @(negedge clk);
        chk("rst_idle", 64'({cmd_ready, busy, done, err, avm_read, avm_write,
                             avm_address, avm_writedata, avm_byteenable}), 64'(rst_exp));
        @(negedge clk);
        inj_rdv = 1'b0;
        repeat (4) @(negedge clk);
        chk("rst_nowrite", 64'(wl_addr.size() - bw), 64'd0);
        chk("rst_stillidle", 64'({cmd_ready, busy, avm_write}), 64'b100);
        do_vec(vr, "post_rst");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
